seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 72, operand/result width (>=8).
REQ-002 SHALL have parameter IMM_WIDTH, default 55, immediate field width for ops 6-8 (< WIDTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  request; accepted when start=1 and busy=0.
REQ-006 SHALL have port op  input  4  opcode, sampled on accept.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, sampled on accept.
REQ-008 SHALL have port c  output  WIDTH  result register.
REQ-009 SHALL have port busy  output  1  high while an iterative MUL/DIV is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse, c and flags valid.
REQ-011 SHALL have port ovf  output  1  carry (add), borrow (sub), or nonzero product upper half (mul).
REQ-012 SHALL have port dz  output  1  divide-by-zero.

Function
REQ-013 Opcodes SHALL be: 0 add, 1 sub, 2 mul, 3 div, 4 lsl, 5 lsr, 6 addi, 7 subi, 8 andi, 9 logical and, 10 logical or, 11 xor, 12 eq, 13 ne, 14 lt, 15 gt.
REQ-014 Arithmetic SHALL be unsigned, modulo 2^WIDTH; ops 6-8 SHALL use b[IMM_WIDTH-1:0] zero-extended.
REQ-015 Ops 9,10,12-15 SHALL return 1 or 0 in c[0], upper bits zero.
REQ-016 Shifts SHALL use the full b as shift amount; b >= WIDTH SHALL yield c=0.
REQ-017 States SHALL be IDLE and ITER; busy = (state==ITER).
REQ-018 Non-iterative ops and div with b=0 SHALL stay in IDLE; c, flags, done=1 registered at the edge ending the accept cycle (latency 1); back-to-back accept every cycle SHALL be supported.
REQ-019 Op 2 SHALL be radix-2 shift-add, op 3 restoring division; accept moves IDLE->ITER, WIDTH iterations, then IDLE with done=1 (latency WIDTH+1 cycles from accept edge).
REQ-020 MUL c SHALL equal low WIDTH bits of a*b; ovf=1 iff upper WIDTH bits nonzero.
REQ-021 DIV c SHALL equal floor(a/b); b=0 SHALL give c=all ones, dz=1, latency 1.
REQ-022 ovf and dz SHALL be 0 for ops that do not define them, and SHALL update together with c.
REQ-023 start while busy=1 SHALL be ignored (no queueing); op/a/b changes during ITER SHALL not affect result.
REQ-024 done SHALL be high exactly one cycle per accepted request and never without one.
REQ-025 c, ovf, dz SHALL hold their last value until the next done.

Reset
REQ-026 rst_n=0 SHALL asynchronously force state=IDLE, c=0, busy=0, done=0, ovf=0, dz=0, iteration counter=0.
REQ-027 Reset during ITER SHALL abort the operation with no done pulse; first accept after release SHALL behave as from power-up.
REQ-028 start SHALL be ignored in the first cycle rst_n is sampled high? No: start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Opcode constants (OP_ADD..OP_GT) and the state encoding SHALL live in shared package seq_alu_pkg.
REQ-030 Iterative multiply/divide datapath (shared WIDTH*2 shift register, $clog2(WIDTH+1)-bit counter) SHALL be sub-module seq_alu_muldiv with start/done handshake; single-cycle ops stay in seq_alu.

Verification
REQ-031 WIDTH=72: add a=2^72-1, b=1 -> c=0, ovf=1, done 1 cycle after accept.
REQ-032 WIDTH=72: mul a=2^40, b=2^40 -> c=0, ovf=1, busy high 72 cycles, done at cycle 73; mul 12x11 -> c=132, ovf=0.
REQ-033 div a=100, b=7 -> c=14, dz=0 after WIDTH+1 cycles; div a=5, b=0 -> c=all ones, dz=1, latency 1.
REQ-034 lsl a=1, b=WIDTH-1 -> c=2^(WIDTH-1); lsl a=1, b=WIDTH -> c=0; addi a=0, b=2^60+3 (IMM_WIDTH=55) -> c=3.
REQ-035 start div, pulse start with op=0 at cycle 10, assert rst_n=0 at cycle 20 -> no done, all outputs 0; new add 2+3 after release -> c=5.
REQ-036 Back-to-back start each cycle with eq(7,7), lt(3,9), gt(3,9) -> done high 3 consecutive cycles, c=1,1,0.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
// Shared definitions for the sequential ALU: opcode encoding, controller
// state encoding and the helper that decides whether an opcode goes through
// the iterative multiply/divide engine.
package seq_alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_LSL  = 4'd4,
        OP_LSR  = 4'd5,
        OP_ADDI = 4'd6,
        OP_SUBI = 4'd7,
        OP_ANDI = 4'd8,
        OP_LAND = 4'd9,
        OP_LOR  = 4'd10,
        OP_XOR  = 4'd11,
        OP_EQ   = 4'd12,
        OP_NE   = 4'd13,
        OP_LT   = 4'd14,
        OP_GT   = 4'd15
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ITER = 1'b1
    } state_e;

    // Divide by zero is resolved in a single cycle, so only MUL and a
    // DIV with a non-zero divisor use the iterative engine.
    function automatic logic is_iter_op(input logic [3:0] op, input logic b_zero);
        return (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv
// Iterative unsigned multiply (radix-2 shift-add) and restoring divide
// sharing one 2*WIDTH shift register. One step per clock for WIDTH clocks.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       load operands and begin (ignored unless caller is idle)
//   is_div      1 = divide a/b, 0 = multiply a*b (sampled on start)
//   a, b        operands (sampled on start)
//   last        high during the final step; result/ovf valid combinationally
//   result      low half after the final step (product low or quotient)
//   ovf         product upper half non-zero (always 0 for divide)
module seq_alu_muldiv #(
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   opnd;
    logic               div_mode;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;

    always_comb begin
        // Multiply: acc = {partial, multiplier}; add multiplicand to the
        // upper half when the multiplier LSB is set, then shift right with
        // the carry folded back in.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Divide: acc = {remainder, dividend/quotient}; shift left one and
        // trial-subtract. The remainder is always < divisor, so the shifted
        // remainder fits in WIDTH+1 bits and diff[WIDTH] is the borrow.
        rem_sh  = acc[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd};
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    assign last   = (cnt == CW'(1));
    assign result = acc_step[WIDTH-1:0];
    assign ovf    = !div_mode && (|acc_step[2*WIDTH-1:WIDTH]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
            cnt      <= '0;
        end else if (start) begin
            acc      <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            opnd     <= is_div ? b : a;
            div_mode <= is_div;
            cnt      <= CW'(WIDTH);
        end else if (cnt != '0) begin
            acc <= acc_step;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
// Sequential unsigned ALU. Single-cycle ops complete at the accept edge;
// MUL and DIV (non-zero divisor) run WIDTH steps in seq_alu_muldiv.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start       request, accepted when busy=0
//   op          opcode (seq_alu_pkg::op_e), sampled on accept
//   a, b        operands, sampled on accept
//   c           result register, held until the next done
//   busy        iterative operation in progress
//   done        one-cycle pulse per accepted request
//   ovf         carry (add) / borrow (sub) / product upper half non-zero
//   dz          divide by zero
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready; single-cycle ops and div-by-zero finish here
// ST_ITER | muldiv engine stepping; start ignored; exits on last step
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH     = 72,
    parameter int IMM_WIDTH = 55
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dz
);

    state_e           state;
    state_e           state_next;
    logic             go_iter;
    logic             load_single;
    logic             load_iter;
    logic             md_last;
    logic [WIDTH-1:0] md_result;
    logic             md_ovf;

    logic [WIDTH-1:0] alu_c;
    logic             alu_ovf;
    logic             alu_dz;
    logic [WIDTH-1:0] imm;
    logic [WIDTH:0]   sum_ext;
    logic             shift_big;
    logic             b_zero;

    assign busy = (state == ST_ITER);

    seq_alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (go_iter),
        .is_div (op == OP_DIV),
        .a      (a),
        .b      (b),
        .last   (md_last),
        .result (md_result),
        .ovf    (md_ovf)
    );

    always_comb begin
        b_zero    = (b == '0);
        imm       = {{(WIDTH-IMM_WIDTH){1'b0}}, b[IMM_WIDTH-1:0]};
        sum_ext   = {1'b0, a} + {1'b0, b};
        shift_big = (b >= WIDTH'(WIDTH));
        alu_c     = '0;
        alu_ovf   = 1'b0;
        alu_dz    = 1'b0;
        case (op)
            OP_ADD: begin
                alu_c   = sum_ext[WIDTH-1:0];
                alu_ovf = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_c   = a - b;
                alu_ovf = (a < b);
            end
            OP_DIV: begin
                // Only reached here with b == 0; non-zero divisors iterate.
                alu_c  = '1;
                alu_dz = 1'b1;
            end
            OP_LSL:  alu_c = shift_big ? '0 : (a << b);
            OP_LSR:  alu_c = shift_big ? '0 : (a >> b);
            OP_ADDI: alu_c = a + imm;
            OP_SUBI: alu_c = a - imm;
            OP_ANDI: alu_c = a & imm;
            OP_LAND: alu_c = {{(WIDTH-1){1'b0}}, (a != '0) && (b != '0)};
            OP_LOR:  alu_c = {{(WIDTH-1){1'b0}}, (a != '0) || (b != '0)};
            OP_XOR:  alu_c = a ^ b;
            OP_EQ:   alu_c = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_NE:   alu_c = {{(WIDTH-1){1'b0}}, (a != b)};
            OP_LT:   alu_c = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_GT:   alu_c = {{(WIDTH-1){1'b0}}, (a > b)};
            default: alu_c = '0;
        endcase
    end

    always_comb begin
        state_next  = state;
        go_iter     = 1'b0;
        load_single = 1'b0;
        load_iter   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (is_iter_op(op, b_zero)) begin
                        go_iter    = 1'b1;
                        state_next = ST_ITER;
                    end else begin
                        load_single = 1'b1;
                    end
                end
            end
            ST_ITER: begin
                if (md_last) begin
                    load_iter  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c    <= '0;
            ovf  <= 1'b0;
            dz   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= load_single || load_iter;
            if (load_single) begin
                c   <= alu_c;
                ovf <= alu_ovf;
                dz  <= alu_dz;
            end else if (load_iter) begin
                c   <= md_result;
                ovf <= md_ovf;
                dz  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W   = 72;
    localparam int IMM = 55;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         busy;
    logic         done;
    logic         ovf;
    logic         dz;

    int n_total = 0;
    int n_pass  = 0;

    seq_alu #(.WIDTH(W), .IMM_WIDTH(IMM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .c     (c),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        logic         ovf;
        logic         dz;
        int           lat;
        int           bcyc;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive a request now; the next rising edge accepts it. Inputs are
    // scrambled after accept so a late-sampling design would be caught.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output int bcnt);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = OP_XOR; a = ~x; b = ~y;
        lat = 1; bcnt = 0;
        while (!done && lat < W + 10) begin
            if (busy) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    logic [W-1:0] all1;
    logic [W-1:0] one;
    logic [W-1:0] prev_c;
    int lat;
    int bcnt;
    int dcount;

    initial begin
        all1 = '1;
        one  = 1;
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;

        //            op       a                  b                    c                    ovf   dz    lat  busy
        vecs.push_back('{OP_ADD,  all1,              one,                 '0,                  1'b1, 1'b0, 1,   0});
        vecs.push_back('{OP_ADD,  72'd2,             72'd3,               72'd5,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_SUB,  72'd3,             72'd5,               all1 - 72'd1,        1'b1, 1'b0, 1,   0});
        vecs.push_back('{OP_SUB,  72'd9,             72'd4,               72'd5,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_MUL,  one << 40,         one << 40,           '0,                  1'b1, 1'b0, W+1, W});
        vecs.push_back('{OP_MUL,  72'd12,            72'd11,              72'd132,             1'b0, 1'b0, W+1, W});
        vecs.push_back('{OP_MUL,  all1,              all1,                72'd1,               1'b1, 1'b0, W+1, W});
        vecs.push_back('{OP_DIV,  72'd100,           72'd7,               72'd14,              1'b0, 1'b0, W+1, W});
        vecs.push_back('{OP_DIV,  72'd5,             72'd0,               all1,                1'b0, 1'b1, 1,   0});
        vecs.push_back('{OP_DIV,  all1,              72'd1,               all1,                1'b0, 1'b0, W+1, W});
        vecs.push_back('{OP_DIV,  72'd7,             72'd100,             '0,                  1'b0, 1'b0, W+1, W});
        vecs.push_back('{OP_LSL,  one,               72'd71,              one << 71,           1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LSL,  one,               72'd72,              '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LSR,  one << 71,         72'd71,              one,                 1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LSR,  all1,              one << 70,           '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_ADDI, '0,                (one << 60) + 72'd3, 72'd3,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_SUBI, 72'd10,            (one << 60) + 72'd3, 72'd7,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_ANDI, all1,              all1,                all1 >> (W-IMM),     1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LAND, 72'd5,             72'd0,               '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LAND, 72'd5,             72'd6,               72'd1,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LOR,  72'd0,             72'd0,               '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LOR,  72'd0,             72'd4,               72'd1,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_XOR,  72'hf0,            72'hff,              72'h0f,              1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_EQ,   72'd7,             72'd7,               72'd1,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_NE,   72'd7,             72'd7,               '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LT,   72'd9,             72'd3,               '0,                  1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_LT,   one,               all1,                72'd1,               1'b0, 1'b0, 1,   0});
        vecs.push_back('{OP_GT,   72'd9,             72'd3,               72'd1,               1'b0, 1'b0, 1,   0});

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_c", c, '0);
        chk("rst_busy", W'(busy), '0);
        chk("rst_done", W'(done), '0);
        chk("rst_ovf", W'(ovf), '0);
        chk("rst_dz", W'(dz), '0);

        // Release and present the first request at once: it must be taken
        // on the first rising edge after release (its latency check covers it).
        rst_n = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            chk($sformatf("v%0d_done", i), W'(done), W'(1));
            chk($sformatf("v%0d_lat", i), W'(lat), W'(vecs[i].lat));
            chk($sformatf("v%0d_busy", i), W'(bcnt), W'(vecs[i].bcyc));
            chk($sformatf("v%0d_c", i), c, vecs[i].c);
            chk($sformatf("v%0d_ovf", i), W'(ovf), W'(vecs[i].ovf));
            chk($sformatf("v%0d_dz", i), W'(dz), W'(vecs[i].dz));
            @(posedge clk); #1;
            chk($sformatf("v%0d_pulse", i), W'(done), '0);
            chk($sformatf("v%0d_hold", i), c, vecs[i].c);
        end

        // Back-to-back single-cycle accepts.
        start = 1'b1; op = OP_EQ; a = 72'd7; b = 72'd7;
        @(posedge clk); #1;
        chk("b2b0_done", W'(done), W'(1));
        chk("b2b0_c", c, 72'd1);
        op = OP_LT; a = 72'd3; b = 72'd9;
        @(posedge clk); #1;
        chk("b2b1_done", W'(done), W'(1));
        chk("b2b1_c", c, 72'd1);
        op = OP_GT; a = 72'd3; b = 72'd9;
        @(posedge clk); #1;
        chk("b2b2_done", W'(done), W'(1));
        chk("b2b2_c", c, '0);
        start = 1'b0;
        @(posedge clk); #1;
        chk("b2b_end_done", W'(done), '0);

        // Leave non-zero outputs behind, then abort a divide with reset.
        run_op(OP_SUB, 72'd3, 72'd5, lat, bcnt);
        chk("pre_abort_ovf", W'(ovf), W'(1));
        @(posedge clk); #1;
        prev_c = c;
        op = OP_DIV; a = 72'd100; b = 72'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        for (int cyc = 1; cyc < 20; cyc++) begin
            if (cyc == 10) begin
                start = 1'b1; op = OP_ADD; a = 72'd2; b = 72'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) dcount++;
        end
        start = 1'b0;
        chk("abort_busy_before", W'(busy), W'(1));
        chk("abort_c_held", c, prev_c);
        chk("abort_no_done", W'(dcount), '0);
        rst_n = 1'b0;
        #1;
        chk("abort_c", c, '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_ovf", W'(ovf), '0);
        chk("abort_dz", W'(dz), '0);
        dcount = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (done) dcount++;
        chk("abort_done", W'(dcount), '0);
        run_op(OP_ADD, 72'd2, 72'd3, lat, bcnt);
        chk("post_rst_lat", W'(lat), W'(1));
        chk("post_rst_c", c, 72'd5);
        chk("post_rst_ovf", W'(ovf), '0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
